// File: rtl/ppr_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ppr_mem_pkg
//  Purpose  : Shared types and constants for the BRAM bank arbiter slice.
//             - idx_width(n) : index width for n items, never below 1
//             - trk_entry_t  : read-tracker entry {is_read, port_id}
//             - c_CNT_W      : width of the saturating conflict counter
//  Revision : 1.0 - initial release
// ============================================================================
package ppr_mem_pkg;

  localparam int c_CNT_W     = 16;
  // Wide enough for the largest supported port count (16)
  localparam int c_PORT_ID_W = 4;

  typedef struct packed {
    logic                   is_read;
    logic [c_PORT_ID_W-1:0] port_id;
  } trk_entry_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant
//  Purpose  : Combinational round-robin pick. Grants the first eligible port
//             at or after the pointer, wrapping modulo NUM_PORTS.
//  Ports    : i_elig      - per-port eligibility
//             i_ptr       - current round-robin pointer (< NUM_PORTS)
//             o_grant     - one-hot grant (zero when nothing eligible)
//             o_grant_idx - binary index of the granted port
//             o_any_grant - at least one port granted
//  Revision : 1.0 - initial release
// ============================================================================
module rr_grant #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] i_elig,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [IDX_W-1:0]     o_grant_idx,
  output logic                 o_any_grant
);

  logic [2*NUM_PORTS-1:0] w_dbl;
  logic [NUM_PORTS-1:0]   w_rot;

  // Doubling the vector lets a plain right shift rotate it so that bit 0
  // corresponds to the port at the pointer.
  assign w_dbl = {i_elig, i_elig};
  assign w_rot = w_dbl[NUM_PORTS-1:0] == '0 ? '0 : NUM_PORTS'(w_dbl >> i_ptr);

  always_comb begin
    int   s;
    logic found;
    s           = 0;
    found       = 1'b0;
    o_grant_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && w_rot[k]) begin
        found = 1'b1;
        s     = int'(i_ptr) + k;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        o_grant_idx = IDX_W'(s);
      end
    end
    o_any_grant = found;
    o_grant     = found ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << o_grant_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/bank_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : bank_arbiter_rr
//  Purpose  : Round-robin arbiter giving NUM_PORTS engines shared access to a
//             single-port BRAM bank owning [LOWER_ADDR, UPPER_ADDR].
//  Ports    : clk, rst_n           - clock, async active-low reset
//             req_valid/we/addr/wdata - per-port requests (packed per port)
//             req_ready            - combinational one-hot grant
//             rsp_valid/rsp_rdata  - registered read response, one-hot port
//             mem_en/we/addr/wdata - registered bank issue (bank-local addr)
//             mem_rdata            - bank read data, MEM_LATENCY after issue
//             conflict/conflict_cnt - registered contention flag / sat. count
//  Revision : 1.0 - initial release
// ============================================================================
module bank_arbiter_rr
  import ppr_mem_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 32,
  parameter int LOWER_ADDR  = 0,
  parameter int UPPER_ADDR  = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             conflict,
  output logic [15:0]                      conflict_cnt
);

  localparam int                    c_IDX_W = idx_width(NUM_PORTS);
  localparam int                    c_TRK_D = MEM_LATENCY + 1;
  localparam logic [ADDR_WIDTH-1:0] c_LOWER = ADDR_WIDTH'(LOWER_ADDR);
  localparam logic [ADDR_WIDTH-1:0] c_UPPER = ADDR_WIDTH'(UPPER_ADDR);

  logic [NUM_PORTS-1:0]  w_elig;
  logic [NUM_PORTS-1:0]  w_grant;
  logic [c_IDX_W-1:0]    w_grant_idx;
  logic                  w_any;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_conflict;
  trk_entry_t            w_push;
  trk_entry_t            w_tail;
  logic [NUM_PORTS-1:0]  w_rsp_hot;

  logic [c_IDX_W-1:0]    r_ptr;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  trk_entry_t            r_trk [c_TRK_D];
  logic [NUM_PORTS-1:0]  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_conflict;
  logic [c_CNT_W-1:0]    r_conflict_cnt;

  // Eligibility: valid and inside the bank window. Bounds that cannot
  // exclude anything are elided so no constant comparison is built.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_elig
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_lo_ok;
    logic                  w_hi_ok;
    assign w_addr = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    if (LOWER_ADDR == 0) begin : g_lo_open
      assign w_lo_ok = 1'b1;
    end else begin : g_lo_cmp
      assign w_lo_ok = (w_addr >= c_LOWER);
    end
    if (longint'(UPPER_ADDR) >= (longint'(1) << ADDR_WIDTH) - 1) begin : g_hi_open
      assign w_hi_ok = 1'b1;
    end else begin : g_hi_cmp
      assign w_hi_ok = (w_addr <= c_UPPER);
    end
    assign w_elig[gi] = req_valid[gi] & w_lo_ok & w_hi_ok;
  end

  rr_grant #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (c_IDX_W)
  ) u_rr_grant (
    .i_elig      (w_elig),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any)
  );

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_grant[i]) begin
        w_sel_we    = req_we[i];
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_conflict     = ($countones(w_elig) > 1);
  assign w_push.is_read = w_any & ~w_sel_we;
  assign w_push.port_id = c_PORT_ID_W'(w_grant_idx);
  assign w_tail         = r_trk[c_TRK_D-1];

  always_comb begin
    w_rsp_hot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_rsp_hot[i] = w_tail.is_read && (w_tail.port_id == c_PORT_ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr          <= '0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_rsp_valid    <= '0;
      r_rsp_rdata    <= '0;
      r_conflict     <= 1'b0;
      r_conflict_cnt <= '0;
      for (int k = 0; k < c_TRK_D; k++) r_trk[k] <= '0;
    end else begin
      r_mem_en <= w_any;
      r_mem_we <= w_any & w_sel_we;
      if (w_any) begin
        r_ptr       <= (w_grant_idx == c_IDX_W'(NUM_PORTS-1)) ? '0 : w_grant_idx + 1'b1;
        r_mem_addr  <= w_sel_addr - c_LOWER;
        r_mem_wdata <= w_sel_wdata;
      end
      // Stage k lines up with the bank cycle k after issue; the tail meets
      // mem_rdata exactly MEM_LATENCY cycles after mem_en.
      r_trk[0] <= w_push;
      for (int k = 1; k < c_TRK_D; k++) r_trk[k] <= r_trk[k-1];
      r_rsp_valid <= w_rsp_hot;
      if (w_tail.is_read) r_rsp_rdata <= mem_rdata;
      r_conflict <= w_conflict;
      if (w_conflict && (r_conflict_cnt != {c_CNT_W{1'b1}})) begin
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
      end
    end
  end

  // Grant is combinational but forced quiet while reset is held
  assign req_ready    = w_grant & {NUM_PORTS{rst_n}};
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign conflict     = r_conflict;
  assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire
